// File: rtl/pipes_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operations,
// PC source select, instruction classes and the opcode/funct constants.
package pipes;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } ctrl_state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_ADDI    = 3'd2,
    CLS_LW      = 3'd3,
    CLS_SW      = 3'd4,
    CLS_BEQ     = 3'd5,
    CLS_J       = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational decode of the latched instruction word into an
// instruction class and the ALU operation it needs in EXEC.
import pipes::*;

module instr_decode (
  input  logic [31:0] ir,
  output logic [2:0]  iclass,
  output logic [2:0]  alu_op
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = ir[31:26];
  assign w_funct  = ir[5:0];

  // An all-zero word is a NOP even though it looks like an R-type with funct 0.
  always_comb begin
    iclass = CLS_ILLEGAL;
    alu_op = ALU_ADD;
    if (ir == 32'd0) begin
      iclass = CLS_NOP;
    end else begin
      case (w_opcode)
        OP_RTYPE: begin
          case (w_funct)
            FN_ADD: begin iclass = CLS_RTYPE; alu_op = ALU_ADD; end
            FN_SUB: begin iclass = CLS_RTYPE; alu_op = ALU_SUB; end
            FN_AND: begin iclass = CLS_RTYPE; alu_op = ALU_AND; end
            FN_OR:  begin iclass = CLS_RTYPE; alu_op = ALU_OR;  end
            FN_SLT: begin iclass = CLS_RTYPE; alu_op = ALU_SLT; end
            default: iclass = CLS_ILLEGAL;
          endcase
        end
        OP_ADDI: iclass = CLS_ADDI;
        OP_LW:   iclass = CLS_LW;
        OP_SW:   iclass = CLS_SW;
        OP_BEQ:  begin iclass = CLS_BEQ; alu_op = ALU_SUB; end
        OP_J:    iclass = CLS_J;
        default: iclass = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller for a small MIPS-like core.
// Control outputs are Moore functions of state and ir; pc_we and the final
// retire of a handshake state also follow the handshake/zero inputs.
import pipes::*;

module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq,
  input  logic        idata_ok,
  input  logic [31:0] idata,
  output logic        dreq,
  output logic        dwe,
  input  logic        ddata_ok,
  input  logic        alu_zero,
  output logic [31:0] ir,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        alu_srcb,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] retired_cnt
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic [31:0] r_ir;
  logic [31:0] r_retiredCnt;

  logic [2:0]  w_class;
  logic [2:0]  w_decAluOp;

  logic        w_ireq;
  logic        w_dreq;
  logic        w_dwe;
  logic        w_pcWe;
  logic [1:0]  w_pcSrc;
  logic [2:0]  w_aluOp;
  logic        w_aluSrcb;
  logic        w_regWe;
  logic        w_regDst;
  logic        w_memToReg;
  logic        w_retire;
  logic        w_illegal;

  instr_decode u_decode (
    .ir     (r_ir),
    .iclass (w_class),
    .alu_op (w_decAluOp)
  );

  always_comb begin
    w_next     = r_state;
    w_ireq     = 1'b0;
    w_dreq     = 1'b0;
    w_dwe      = 1'b0;
    w_pcWe     = 1'b0;
    w_pcSrc    = PC_SRC_SEQ;
    w_aluOp    = ALU_ADD;
    w_aluSrcb  = 1'b0;
    w_regWe    = 1'b0;
    w_regDst   = 1'b0;
    w_memToReg = 1'b0;
    w_retire   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      // A response in the first request cycle completes the fetch at once.
      ST_FETCH: begin
        w_ireq = 1'b1;
        if (idata_ok) begin
          w_pcWe = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_class)
          CLS_J: begin
            w_pcWe   = 1'b1;
            w_pcSrc  = PC_SRC_JUMP;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          CLS_NOP: begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          CLS_ILLEGAL: begin
            w_illegal = 1'b1;
            w_next    = ST_FETCH;
          end
          default: w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        w_aluOp = w_decAluOp;
        case (w_class)
          CLS_RTYPE: w_next = ST_WB;
          CLS_ADDI: begin
            w_aluSrcb = 1'b1;
            w_next    = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            w_aluSrcb = 1'b1;
            w_next    = ST_MEM;
          end
          CLS_BEQ: begin
            w_pcSrc  = PC_SRC_BRANCH;
            w_pcWe   = alu_zero;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        w_dreq = 1'b1;
        w_dwe  = (w_class == CLS_SW);
        if (ddata_ok) begin
          if (w_class == CLS_SW) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_regWe    = 1'b1;
        w_regDst   = (w_class == CLS_RTYPE);
        w_memToReg = (w_class == CLS_LW);
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_ir         <= 32'd0;
      r_retiredCnt <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH && idata_ok) begin
        r_ir <= idata;
      end
      if (w_retire) begin
        r_retiredCnt <= r_retiredCnt + 32'd1;
      end
    end
  end

  // While reset is held the FSM sits in FETCH, so gate every output to keep
  // the bus quiet instead of advertising a fetch request.
  assign ireq        = w_ireq & ~reset;
  assign dreq        = w_dreq & ~reset;
  assign dwe         = w_dwe & ~reset;
  assign pc_we       = w_pcWe & ~reset;
  assign pc_src      = reset ? PC_SRC_SEQ : w_pcSrc;
  assign alu_op      = reset ? ALU_ADD : w_aluOp;
  assign alu_srcb    = w_aluSrcb & ~reset;
  assign reg_we      = w_regWe & ~reset;
  assign reg_dst     = w_regDst & ~reset;
  assign mem_to_reg  = w_memToReg & ~reset;
  assign retire      = w_retire & ~reset;
  assign illegal     = w_illegal & ~reset;
  assign state       = r_state;
  assign ir          = r_ir;
  assign retired_cnt = r_retiredCnt;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset, with ports in this order: clk (in, 1, rising-edge clock), reset (in, 1, async active-high reset).
REQ-002 SHALL provide these instruction-fetch ports: ireq (out, 1, fetch request); idata_ok (in, 1, fetch done); idata (in, 32, fetched word).
REQ-003 SHALL provide these data-memory ports: dreq (out, 1, data access request); dwe (out, 1, 1=store); ddata_ok (in, 1, access done).
REQ-004 SHALL provide alu_zero (in, 1): datapath ALU zero flag, valid in EXEC.
REQ-005 SHALL provide the instruction-register and PC outputs: ir (out, 32, latched instruction); pc_we (out, 1, PC write); pc_src (out, 2, 0=PC+4, 1=branch target, 2=jump target).
REQ-006 SHALL provide these datapath control outputs:
- alu_op (out, 3, alu_op_t)
- alu_srcb (out, 1, 0=reg rt, 1=sign-extended imm16)
- reg_we (out, 1)
- reg_dst (out, 1, 0=rt, 1=rd)
- mem_to_reg (out, 1)
REQ-007 SHALL provide status outputs: state (out, 3, ctrl_state_t); retire (out, 1, one-cycle pulse per completed instruction); illegal (out, 1, one-cycle pulse on an undecodable word); retired_cnt (out, 32).

Function
REQ-008 SHALL implement the states FETCH, DECODE, EXEC, MEM and WB.
REQ-009 SHALL, in FETCH, hold ireq=1 until idata_ok=1; on that cycle it SHALL load ir<=idata, assert pc_we with pc_src=0, and go to DECODE. If idata_ok never arrives, the block SHALL stay in FETCH indefinitely.
REQ-010 SHALL decode, in DECODE, by opcode ir[31:26]:
- 000000: R-type, selected by funct ir[5:0]
- 001000: ADDI
- 100011: LW
- 101011: SW
- 000100: BEQ
- 000010: J
REQ-011 SHALL treat R-type funct 100000/100010/100100/100101/101010 as ADD/SUB/AND/OR/SLT; an all-zero ir SHALL be NOP.
REQ-012 SHALL, in DECODE: for J, assert pc_we with pc_src=2, pulse retire and go to FETCH; for NOP, pulse retire and go to FETCH; otherwise go to EXEC.
REQ-013 SHALL, in DECODE, for an unknown opcode or unknown R-type funct, pulse illegal, leave retire and retired_cnt unchanged, perform no register or memory write, and go to FETCH.
REQ-014 SHALL, in EXEC: for R-type, drive alu_op from funct with alu_srcb=0 and go to WB; for ADDI/LW/SW, drive alu_op=ADD with alu_srcb=1, then go to WB for ADDI or to MEM for LW/SW.
REQ-015 SHALL, in EXEC for BEQ, drive alu_op=SUB with alu_srcb=0; if alu_zero=1 it SHALL assert pc_we with pc_src=1. It SHALL then pulse retire and go to FETCH.
REQ-016 SHALL, in MEM, hold dreq=1 (with dwe=1 for SW, 0 for LW) until ddata_ok=1; then SW SHALL pulse retire and go to FETCH, and LW SHALL go to WB.
REQ-017 SHALL, in WB, assert reg_we=1 for one cycle: reg_dst=1 for R-type, 0 for ADDI/LW; mem_to_reg=1 for LW only. It SHALL then pulse retire and go to FETCH.
REQ-018 SHALL drive all control outputs as combinational functions of state and ir (Moore style), except pc_we, which may depend on idata_ok and alu_zero. Outputs not named for a state SHALL be 0.
REQ-019 SHALL have the following latencies, with zero-wait handshakes: J/NOP 2 cycles; BEQ 3; R-type/ADDI/SW 4; LW 5. Each handshake wait cycle SHALL add exactly one cycle.
REQ-020 SHALL increment retired_cnt by 1 on every retire pulse and wrap from 0xFFFFFFFF to 0.
REQ-021 SHALL not drop a response that arrives in the same cycle its request is first raised; that response completes the access.
REQ-022 SHALL assert at most one of ireq and dreq in any cycle.

Reset
REQ-023 SHALL, while reset=1 (asynchronous), set state=FETCH, ir=0 and retired_cnt=0, and force all pulse and control outputs to 0.
REQ-024 SHALL, on reset asserted mid-access (FETCH or MEM waiting), abandon the access; no reg_we or retire SHALL follow. After reset deasserts, the block SHALL raise ireq on the next edge.

Structure
REQ-025 SHALL place ctrl_state_t (3-bit enum), alu_op_t (ADD, SUB, AND, OR, SLT) and pc_src encodings in package pipes, alongside the existing opcode and funct constants.
REQ-026 SHALL implement decode as one combinational sub-module, instr_decode (ir in, instruction class and alu_op out), used by multicycle_ctrl.

Verification
REQ-027 SHALL cover ADD: idata=0x012A4020 with idata_ok same cycle -> sequence FETCH,DECODE,EXEC,WB; alu_op=ADD; reg_we=1 with reg_dst=1 in cycle 4; retire pulse; retired_cnt=1.
REQ-028 SHALL cover LW: idata=0x8D280004 and ddata_ok delayed 3 cycles -> dreq held 4 cycles with dwe=0; then WB with mem_to_reg=1 and reg_dst=0; total 8 cycles.
REQ-029 SHALL cover BEQ: idata=0x10220003 with alu_zero=1 -> EXEC asserts pc_we with pc_src=1. With alu_zero=0 -> no pc_we in EXEC. Both cases retire in 3 cycles.
REQ-030 SHALL cover J and illegal words: idata=0x08000010 -> DECODE asserts pc_we with pc_src=2, and retire in cycle 2. idata=0xFC000000 -> illegal pulse; retired_cnt unchanged; reg_we, dreq and retire never asserted.
REQ-031 SHALL cover reset mid-MEM: SW 0xAD280000 with reset asserted while dreq=1 -> immediate state=FETCH with all outputs 0; after release ireq=1 and retired_cnt=0.
